// File: rtl/opcode_attr_table.sv
// Writable multi-port opcode attribute table for the x86 decoder, cleared entry by entry after reset.
// Optional per-port accepted-lookup counters are enabled by defining OPATTR_CNT_EN.
module opcode_attr_table #(
  parameter int ENTRY_W   = 23,
  parameter int NUM_PORTS = 2,
  parameter int MAPS      = 2,
  parameter int MAP_W     = $clog2(MAPS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         init_busy,
  input  logic                         wr_en,
  input  logic [MAP_W-1:0]             wr_map,
  input  logic [7:0]                   wr_opcode,
  input  logic [ENTRY_W-1:0]           wr_data,
  output logic                         wr_ack,
`ifdef OPATTR_CNT_EN
  input  logic                         cnt_clr,
  output logic [NUM_PORTS*16-1:0]      lk_count,
`endif
  input  logic [NUM_PORTS-1:0]         lk_valid,
  output logic [NUM_PORTS-1:0]         lk_ready,
  input  logic [NUM_PORTS*MAP_W-1:0]   lk_map,
  input  logic [NUM_PORTS*8-1:0]       lk_opcode,
  output logic [NUM_PORTS-1:0]         rsp_valid,
  input  logic [NUM_PORTS-1:0]         rsp_ready,
  output logic [NUM_PORTS*ENTRY_W-1:0] rsp_data,
  output logic [NUM_PORTS-1:0]         rsp_miss
);

  localparam int IDX_W   = MAP_W + 8;
  localparam int ENTRIES = MAPS * 256;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [MAP_W:0]   MAPS_L   = (MAP_W + 1)'(MAPS);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic               init_busy_r;
  logic               wr_ack_r;
  logic               wr_ok_s;
  logic [IDX_W-1:0]   wr_addr_s;
  logic [ENTRY_W-1:0] mem_r [ENTRIES];

  // Only RUN writes to an existing map are accepted; everything else is dropped silently.
  assign wr_ok_s   = (state_r == ST_RUN) && wr_en && ({1'b0, wr_map} < MAPS_L);
  assign wr_addr_s = {wr_map, wr_opcode};
  assign init_busy = init_busy_r;
  assign wr_ack    = wr_ack_r;

  // Clear sweep sequencing: INIT walks every entry once, then RUN until the next reset.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_INIT: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
          idx_nxt_s   = '0;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_INIT;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Control registers: state, clear index, busy flag and write acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      idx_r       <= '0;
      init_busy_r <= 1'b1;
      wr_ack_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      init_busy_r <= (state_nxt_s == ST_INIT);
      wr_ack_r    <= wr_ok_s;
    end
  end

  // Table storage: the clear sweep owns the array during INIT, the write port afterwards.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[idx_r] <= '0;
    end else if (wr_ok_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [MAP_W-1:0]   map_s;
    logic [IDX_W-1:0]   addr_s;
    logic               map_ok_s;
    logic               acc_s;
    logic [ENTRY_W-1:0] rd_s;
    logic [ENTRY_W-1:0] data_r;
    logic               valid_r;
    logic               miss_r;

    assign map_s       = lk_map[p*MAP_W +: MAP_W];
    assign addr_s      = {map_s, lk_opcode[p*8 +: 8]};
    assign map_ok_s    = ({1'b0, map_s} < MAPS_L);
    assign lk_ready[p] = !init_busy_r && (!valid_r || rsp_ready[p]);
    assign acc_s       = lk_valid[p] && lk_ready[p];

    // Per-port read mux; a same-cycle write to the same entry is forwarded (write-first).
    always_comb begin
      rd_s = '0;
      if (!map_ok_s) begin
        rd_s = '0;
      end else if (wr_ok_s && (wr_addr_s == addr_s)) begin
        rd_s = wr_data;
      end else begin
        rd_s = mem_r[addr_s];
      end
    end

    // Response slot: loaded on accept, held until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_r <= 1'b0;
        data_r  <= '0;
        miss_r  <= 1'b0;
      end else if (acc_s) begin
        valid_r <= 1'b1;
        data_r  <= rd_s;
        miss_r  <= (rd_s == '0);
      end else if (rsp_ready[p]) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    assign rsp_valid[p]                   = valid_r;
    assign rsp_data[p*ENTRY_W +: ENTRY_W] = data_r;
    assign rsp_miss[p]                    = miss_r;

`ifdef OPATTR_CNT_EN
    logic [15:0] cnt_r;

    // Saturating accept counter; clear has priority over a same-cycle accept.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_r <= 16'h0000;
      end else if (cnt_clr) begin
        cnt_r <= 16'h0000;
      end else if (acc_s && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'h0001;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign lk_count[p*16 +: 16] = cnt_r;
`endif
  end

endmodule

// File: tb/tb_opcode_attr_table.sv
// Randomised and directed bench for opcode_attr_table, checked against an array-based table model.
// Counter checks are compiled in when OPATTR_CNT_EN is defined.
module tb_opcode_attr_table;
  localparam int ENTRY_W = 23;
  localparam int NP      = 2;
  localparam int MAP_W   = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              init_busy;
  logic              wr_en;
  logic [MAP_W-1:0]  wr_map;
  logic [7:0]        wr_opcode;
  logic [ENTRY_W-1:0] wr_data;
  logic              wr_ack;
  logic [NP-1:0]     lk_valid;
  logic [NP-1:0]     lk_ready;
  logic [NP*MAP_W-1:0] lk_map;
  logic [NP*8-1:0]   lk_opcode;
  logic [NP-1:0]     rsp_valid;
  logic [NP-1:0]     rsp_ready;
  logic [NP*ENTRY_W-1:0] rsp_data;
  logic [NP-1:0]     rsp_miss;
`ifdef OPATTR_CNT_EN
  logic              cnt_clr;
  logic [NP*16-1:0]  lk_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [ENTRY_W-1:0] model [512];

  always #5 clk = ~clk;

  opcode_attr_table dut (
    .clk(clk), .reset_n(reset_n), .init_busy(init_busy),
    .wr_en(wr_en), .wr_map(wr_map), .wr_opcode(wr_opcode), .wr_data(wr_data), .wr_ack(wr_ack),
`ifdef OPATTR_CNT_EN
    .cnt_clr(cnt_clr), .lk_count(lk_count),
`endif
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_map(lk_map), .lk_opcode(lk_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_miss(rsp_miss)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int edges;
    int bad;
    reset_n = 1'b0; wr_en = 1'b1; wr_map = 1'b1; wr_opcode = 8'h55; wr_data = 23'h7FFFFF;
    lk_valid = 2'b01; lk_map = 2'b00; lk_opcode = 16'h0001; rsp_ready = 2'b11;
`ifdef OPATTR_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({init_busy, wr_ack, rsp_valid, rsp_miss, lk_ready} !== {1'b1, 1'b0, 2'b00, 2'b00, 2'b00}) begin
      err_cnt++;
      $display("FAIL reset_ctl got %b exp %b", {init_busy, wr_ack, rsp_valid, rsp_miss, lk_ready}, 8'b1000_0000);
    end
    vec_cnt++;
    if (rsp_data !== 46'h0) begin
      err_cnt++; $display("FAIL reset_data got %h exp 0", rsp_data);
    end
    reset_n = 1'b1;
    edges = 0; bad = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (init_busy !== 1'b1) begin
        edges = k;
        break;
      end
      if (lk_ready !== 2'b00 || wr_ack !== 1'b0) bad++;
    end
    wr_en = 1'b0;
    vec_cnt++;
    if (edges !== 512) begin
      err_cnt++; $display("FAIL init_len got %0d exp 512", edges);
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++; $display("FAIL init_blocked got %0d bad cycles exp 0", bad);
    end
`ifdef OPATTR_CNT_EN
    vec_cnt++;
    if (lk_count !== 32'h0) begin
      err_cnt++; $display("FAIL cnt_init got %h exp 0", lk_count);
    end
`endif
    tick();
    lk_valid = 2'b00;
    vec_cnt++;
    if ({rsp_valid[0], rsp_data[22:0], rsp_miss[0]} !== {1'b1, 23'h0, 1'b1}) begin
      err_cnt++; $display("FAIL first_lookup got v=%b d=%h m=%b exp v=1 d=0 m=1", rsp_valid[0], rsp_data[22:0], rsp_miss[0]);
    end
    tick();
    for (int i = 0; i < 512; i++) model[i] = 23'h0;
  endtask

  task automatic test_write;
    wr_en = 1'b1; wr_map = 1'b0; wr_opcode = 8'h01; wr_data = 23'h4C7800;
    model[9'h001] = 23'h4C7800;
    tick();
    wr_en = 1'b0;
    vec_cnt++;
    if (wr_ack !== 1'b1) begin err_cnt++; $display("FAIL wr_ack got %b exp 1", wr_ack); end
    tick();
    vec_cnt++;
    if (wr_ack !== 1'b0) begin err_cnt++; $display("FAIL wr_ack_pulse got %b exp 0", wr_ack); end
    lk_valid = 2'b01; lk_map = 2'b00; lk_opcode = 16'h0001;
    #1;
    vec_cnt++;
    if (lk_ready !== 2'b11) begin err_cnt++; $display("FAIL run_ready got %b exp 11", lk_ready); end
    tick();
    lk_valid = 2'b00;
    vec_cnt++;
    if ({rsp_valid[0], rsp_data[22:0], rsp_miss[0]} !== {1'b1, 23'h4C7800, 1'b0}) begin
      err_cnt++; $display("FAIL lookup_hit got v=%b d=%h m=%b exp v=1 d=4c7800 m=0", rsp_valid[0], rsp_data[22:0], rsp_miss[0]);
    end
    tick();
    vec_cnt++;
    if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL rsp_drop got %b exp 00", rsp_valid); end
  endtask

  task automatic test_collision;
    wr_en = 1'b1; wr_map = 1'b1; wr_opcode = 8'hAF; wr_data = 23'h2A0000;
    model[9'h1AF] = 23'h2A0000;
    lk_valid = 2'b10; lk_map = 2'b10; lk_opcode = 16'hAF00;
    tick();
    wr_en = 1'b0; lk_valid = 2'b00;
    vec_cnt++;
    if ({wr_ack, rsp_valid[1], rsp_data[45:23], rsp_miss[1]} !== {1'b1, 1'b1, 23'h2A0000, 1'b0}) begin
      err_cnt++; $display("FAIL bypass got ack=%b v=%b d=%h exp ack=1 v=1 d=2a0000", wr_ack, rsp_valid[1], rsp_data[45:23]);
    end
    tick();
    lk_valid = 2'b11; lk_map = 2'b00; lk_opcode = 16'h0101;
    tick();
    lk_valid = 2'b00;
    vec_cnt++;
    if ({rsp_valid, rsp_data} !== {2'b11, 23'h4C7800, 23'h4C7800}) begin
      err_cnt++; $display("FAIL same_addr got v=%b d=%h exp both 4c7800", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [ENTRY_W-1:0] v [4];
    v[0] = 23'h123456; v[1] = 23'h0ABCDE; v[2] = 23'h000001; v[3] = 23'h7F0F0F;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_map = 1'b0; wr_opcode = 8'(8'h10 + i); wr_data = v[i];
      model[9'(9'h010 + i)] = v[i];
      tick();
    end
    wr_en = 1'b0;
    rsp_ready = 2'b10; lk_valid = 2'b11; lk_map = 2'b00; lk_opcode = 16'h1010;
    tick();
    for (int c = 0; c < 3; c++) begin
      vec_cnt++;
      if ({rsp_valid, rsp_data[22:0], rsp_data[45:23]} !== {2'b11, v[0], v[c]}) begin
        err_cnt++; $display("FAIL stall_%0d got v=%b p0=%h p1=%h exp p0=%h p1=%h", c, rsp_valid, rsp_data[22:0], rsp_data[45:23], v[0], v[c]);
      end
      lk_opcode[15:8] = 8'(8'h11 + c);
      #1;
      vec_cnt++;
      if (lk_ready !== 2'b10) begin err_cnt++; $display("FAIL stall_ready_%0d got %b exp 10", c, lk_ready); end
      tick();
    end
    vec_cnt++;
    if (rsp_data[45:23] !== v[3]) begin err_cnt++; $display("FAIL stream_last got %h exp %h", rsp_data[45:23], v[3]); end
    rsp_ready = 2'b11; lk_valid = 2'b01; lk_opcode[7:0] = 8'h11;
    #1;
    vec_cnt++;
    if (lk_ready[0] !== 1'b1) begin err_cnt++; $display("FAIL release_ready got %b exp 1", lk_ready[0]); end
    tick();
    lk_valid = 2'b00;
    vec_cnt++;
    if ({rsp_valid, rsp_data[22:0]} !== {2'b01, v[1]}) begin
      err_cnt++; $display("FAIL release_data got v=%b d=%h exp v=01 d=%h", rsp_valid, rsp_data[22:0], v[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_init;
    int edges;
    rsp_ready = 2'b00; lk_valid = 2'b01; lk_map = 2'b01; lk_opcode = 16'h00AF;
    tick();
    lk_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({rsp_valid, init_busy} !== 3'b001) begin
      err_cnt++; $display("FAIL run_reset got v=%b busy=%b exp v=00 busy=1", rsp_valid, init_busy);
    end
    rsp_ready = 2'b11;
    tick();
    reset_n = 1'b1;
    repeat (100) tick();
    vec_cnt++;
    if (init_busy !== 1'b1) begin err_cnt++; $display("FAIL init_100 got %b exp 1", init_busy); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    edges = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (init_busy !== 1'b1) begin
        edges = k;
        break;
      end
    end
    vec_cnt++;
    if (edges !== 512) begin err_cnt++; $display("FAIL reinit_len got %0d exp 512", edges); end
    lk_valid = 2'b10; lk_map = 2'b10; lk_opcode = 16'hAF00;
    tick();
    lk_valid = 2'b00;
    vec_cnt++;
    if ({rsp_valid[1], rsp_data[45:23], rsp_miss[1]} !== {1'b1, 23'h0, 1'b1}) begin
      err_cnt++; $display("FAIL cleared got v=%b d=%h m=%b exp v=1 d=0 m=1", rsp_valid[1], rsp_data[45:23], rsp_miss[1]);
    end
    tick();
    for (int i = 0; i < 512; i++) model[i] = 23'h0;
  endtask

  task automatic test_random;
    logic [NP-1:0]      exp_valid;
    logic [ENTRY_W-1:0] exp_data [NP];
    logic [NP-1:0]      exp_ready;
    logic               exp_ack;
    logic [ENTRY_W-1:0] got;
    exp_valid = '0;
    exp_data[0] = 23'h0; exp_data[1] = 23'h0;
    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_map = 1'($urandom_range(0, 1));
      wr_opcode = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
      for (int p = 0; p < NP; p++) begin
        lk_valid[p] = ($urandom_range(0, 3) != 0);
        rsp_ready[p] = ($urandom_range(0, 2) != 0);
        lk_map[p] = 1'($urandom_range(0, 1));
        lk_opcode[p*8 +: 8] = 8'($urandom_range(0, 7));
      end
      #1;
      for (int p = 0; p < NP; p++) exp_ready[p] = !exp_valid[p] || rsp_ready[p];
      vec_cnt++;
      if (lk_ready !== exp_ready) begin err_cnt++; $display("FAIL rnd_ready_%0d got %b exp %b", n, lk_ready, exp_ready); end
      exp_ack = wr_en;
      if (wr_en) model[{wr_map, wr_opcode}] = wr_data;
      for (int p = 0; p < NP; p++) begin
        if (lk_valid[p] && exp_ready[p]) begin
          exp_valid[p] = 1'b1;
          exp_data[p] = model[{lk_map[p], lk_opcode[p*8 +: 8]}];
        end else if (rsp_ready[p]) begin
          exp_valid[p] = 1'b0;
        end
      end
      tick();
      vec_cnt++;
      if ({wr_ack, rsp_valid} !== {exp_ack, exp_valid}) begin
        err_cnt++; $display("FAIL rnd_valid_%0d got ack=%b v=%b exp ack=%b v=%b", n, wr_ack, rsp_valid, exp_ack, exp_valid);
      end
      for (int p = 0; p < NP; p++) begin
        if (exp_valid[p]) begin
          got = rsp_data[p*ENTRY_W +: ENTRY_W];
          vec_cnt++;
          if ({got, rsp_miss[p]} !== {exp_data[p], (exp_data[p] == 23'h0)}) begin
            err_cnt++; $display("FAIL rnd_data_%0d_p%0d got %h/%b exp %h", n, p, got, rsp_miss[p], exp_data[p]);
          end
        end
      end
    end
    wr_en = 1'b0; lk_valid = 2'b00; rsp_ready = 2'b11;
    tick();
  endtask

`ifdef OPATTR_CNT_EN
  task automatic test_counter;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    vec_cnt++;
    if (lk_count !== 32'h0) begin err_cnt++; $display("FAIL cnt_clr got %h exp 0", lk_count); end
    lk_valid = 2'b01; lk_map = 2'b00; lk_opcode = 16'h0001;
    repeat (5) tick();
    lk_valid = 2'b00;
    tick();
    vec_cnt++;
    if (lk_count !== 32'h0000_0005) begin err_cnt++; $display("FAIL cnt_five got %h exp 00000005", lk_count); end
    cnt_clr = 1'b1; lk_valid = 2'b01;
    tick();
    cnt_clr = 1'b0; lk_valid = 2'b00;
    tick();
    vec_cnt++;
    if (lk_count !== 32'h0) begin err_cnt++; $display("FAIL cnt_clr_wins got %h exp 0", lk_count); end
    lk_valid = 2'b01;
    repeat (65535) tick();
    vec_cnt++;
    if (lk_count[15:0] !== 16'hFFFF) begin err_cnt++; $display("FAIL cnt_reach got %h exp ffff", lk_count[15:0]); end
    repeat (70000 - 65535) tick();
    lk_valid = 2'b00;
    tick();
    vec_cnt++;
    if (lk_count !== 32'h0000_FFFF) begin err_cnt++; $display("FAIL cnt_sat got %h exp 0000ffff", lk_count); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_collision();
    test_back_to_back();
    test_reset_mid_init();
    test_random();
`ifdef OPATTR_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
